uop_queue: RTL and testbench
============================

UOP_QUEUE -- requirements
Module: uop_queue

Interface
REQ-001 SHALL have parameter NUM_UOPS, default 2: uops per cycle on both the enqueue and the dequeue side.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries; power of two, at least 2*NUM_UOPS.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port IN_uop, input, NUM_UOPS*97 bits: decoded uops from the decoder, lane i at [i*97+:97].
REQ-006 SHALL have port IN_valid, input, NUM_UOPS bits: per-lane enqueue request; any lane pattern is legal, including 2'b10.
REQ-007 SHALL have port OUT_ready, output, 1 bit: the queue accepts all valid input lanes this cycle.
REQ-008 SHALL have port IN_invalidate, input, 1 bit: flush the whole queue (branch mispredict or trap).
REQ-009 SHALL have port IN_stall, input, 1 bit: the rename stage does not accept the output this cycle.
REQ-010 SHALL have port OUT_uop, output, NUM_UOPS*97 bits: the uops at the head of the queue, oldest in lane 0.
REQ-011 SHALL have port OUT_valid, output, NUM_UOPS bits: per-lane output valid, always packed from lane 0 upward.
REQ-012 SHALL have port OUT_count, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-013 SHALL treat a lane as enqueued when IN_valid[i] && OUT_ready && !IN_invalidate.
REQ-014 SHALL compact enqueued lanes in lane order into consecutive entries at the tail; with 2'b10 only lane 1 is written, into a single entry.
REQ-015 SHALL derive OUT_ready from the registered count: OUT_ready = (DEPTH - count) >= NUM_UOPS.
REQ-016 SHALL drive OUT_valid lanes 0..min(count,NUM_UOPS)-1 and drive zeros on all other lanes.
REQ-017 SHALL drive OUT_uop lane k with entry head+k, with bit 0 of each lane forced equal to OUT_valid[k].
REQ-018 SHALL dequeue every valid output lane when IN_stall=0 and IN_invalidate=0; SHALL never dequeue part of a stalled group.
REQ-019 SHALL update count as count + nEnq - nDeq when enqueue and dequeue happen in the same cycle.
REQ-020 SHALL advance head and tail modulo DEPTH; entries written across the wrap stay in order.
REQ-021 SHALL, on IN_invalidate, set head, tail and count to 0 on the next edge; the same-cycle enqueue is dropped and no dequeue is counted.
REQ-022 SHALL have an enqueue-to-output latency of 1 cycle: a uop written at edge N is visible at OUT after edge N, unless bypassed per REQ-026.
REQ-023 SHALL treat the uop payload as opaque and never modify it, apart from bit 0.

Reset
REQ-024 SHALL, on rst, clear head, tail and count to 0; after reset OUT_valid=0, OUT_uop=0, OUT_count=0 and OUT_ready=1.
REQ-025 SHALL give rst priority over IN_invalidate, enqueue and dequeue; reset mid-operation discards all entries, and entry storage need not be reset.

Configuration
REQ-026 SHALL support macro UOPQ_BYPASS_EN; when defined and count==0, valid input lanes appear compacted on OUT combinationally in the same cycle.
REQ-027 SHALL, with UOPQ_BYPASS_EN defined, count a bypassed lane as dequeued when IN_stall=0, so it is not written; when IN_stall=1 it is enqueued normally.
REQ-028 SHALL, without UOPQ_BYPASS_EN, have no combinational path from IN_* to OUT_* and keep the latency of REQ-022.

Structure
REQ-029 SHALL take UOP_W=97, the uop field offsets (valid bit 0, branchPred bit 1, branchID 7:2, fu 9:8, opcode 15:10, pc 64:33, imm 96:65) and NUM_UOPS from the shared uop package.
REQ-030 SHALL put entry storage in one sub-module, uop_queue_ram: NUM_UOPS write ports, NUM_UOPS asynchronous read ports.

Verification
REQ-031 SHALL cover reset: rst for 2 cycles -> OUT_valid=00, OUT_count=0, OUT_ready=1.
REQ-032 SHALL cover fill: IN_valid=11 each cycle with IN_stall=1 -> OUT_ready drops to 0 once count reaches 8, and count=8.
REQ-033 SHALL cover sparse enqueue: enqueue 10, then 01, then 11 with stall released -> output order is uop1, uop0', then the pair, with no gaps.
REQ-034 SHALL cover wrap: 20 cycles of alternating 2-in/1-out traffic -> FIFO order preserved across pointer wrap, checked against a scoreboard.
REQ-035 SHALL cover flush: IN_invalidate while count=5 with IN_valid=11 -> count=0, OUT_valid=00 the next cycle, and the dropped uops never appear.
REQ-036 SHALL cover bypass: with UOPQ_BYPASS_EN, empty queue and IN_valid=11, IN_stall=0 -> same-cycle OUT_valid=11 and count stays 0; without the macro, OUT_valid=11 one cycle later.

Source files
------------

// File: rtl/uop_queue_pkg.sv
// Shared uop definitions for the decode-to-rename queue: payload width, field
// offsets and the default number of uops per cycle.
package uop_queue_pkg;

  localparam int unsigned UOP_W    = 97;
  localparam int unsigned NUM_UOPS = 2;

  // Field offsets within a 97-bit uop
  localparam int unsigned UOP_VALID_BIT   = 0;
  localparam int unsigned UOP_BPRED_BIT   = 1;
  localparam int unsigned UOP_BRID_LSB    = 2;
  localparam int unsigned UOP_BRID_MSB    = 7;
  localparam int unsigned UOP_FU_LSB      = 8;
  localparam int unsigned UOP_FU_MSB      = 9;
  localparam int unsigned UOP_OPCODE_LSB  = 10;
  localparam int unsigned UOP_OPCODE_MSB  = 15;
  localparam int unsigned UOP_PC_LSB      = 33;
  localparam int unsigned UOP_PC_MSB      = 64;
  localparam int unsigned UOP_IMM_LSB     = 65;
  localparam int unsigned UOP_IMM_MSB     = 96;

  typedef logic [UOP_W-1:0] uop_t;

endpackage

// File: rtl/uop_queue_ram.sv
// Entry storage for uop_queue: NUM_UOPS write ports, NUM_UOPS asynchronous read
// ports. Storage is not reset.
module uop_queue_ram #(
  parameter int unsigned NUM_UOPS = 2,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 97
) (
  input  logic                                clk,
  input  logic [NUM_UOPS-1:0]                 we,
  input  logic [NUM_UOPS*$clog2(DEPTH)-1:0]   waddr,
  input  logic [NUM_UOPS*WIDTH-1:0]           wdata,
  input  logic [NUM_UOPS*$clog2(DEPTH)-1:0]   raddr,
  output logic [NUM_UOPS*WIDTH-1:0]           rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write addresses are always distinct, so port order never matters
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_UOPS; i++) begin
      if (we[i]) mem[waddr[i*AW+:AW]] <= wdata[i*WIDTH+:WIDTH];
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < NUM_UOPS; k++) begin
      rdata[k*WIDTH+:WIDTH] = mem[raddr[k*AW+:AW]];
    end
  end

endmodule

// File: rtl/uop_queue.sv
// Multi-lane uop FIFO between decode and rename. Optional same-cycle bypass
// of an empty queue is enabled by defining UOPQ_BYPASS_EN.
module uop_queue #(
  parameter int unsigned NUM_UOPS = uop_queue_pkg::NUM_UOPS,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_UOPS*uop_queue_pkg::UOP_W-1:0] IN_uop,
  input  logic [NUM_UOPS-1:0]                      IN_valid,
  output logic                                     OUT_ready,
  input  logic                                     IN_invalidate,
  input  logic                                     IN_stall,
  output logic [NUM_UOPS*uop_queue_pkg::UOP_W-1:0] OUT_uop,
  output logic [NUM_UOPS-1:0]                      OUT_valid,
  output logic [$clog2(DEPTH):0]                   OUT_count
);
  import uop_queue_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic [NUM_UOPS-1:0]      enq, we;
  logic [NUM_UOPS*AW-1:0]   waddr, raddr;
  logic [NUM_UOPS*UOP_W-1:0] rdata;
  logic [CW-1:0]            n_wr, n_out, n_deq;
  logic                     bypass;

  assign OUT_ready = (count_q <= CW'(DEPTH - NUM_UOPS));
  assign OUT_count = count_q;

  always_comb begin
    enq = IN_valid & {NUM_UOPS{OUT_ready && !IN_invalidate}};
`ifdef UOPQ_BYPASS_EN
    bypass = (count_q == '0);
`else
    bypass = 1'b0;
`endif
    // A bypassed group that rename accepts is consumed and never stored
    we = (bypass && !IN_stall) ? '0 : enq;

    n_wr  = '0;
    waddr = '0;
    for (int unsigned i = 0; i < NUM_UOPS; i++) begin
      waddr[i*AW+:AW] = tail_q + n_wr[AW-1:0];
      if (we[i]) n_wr = n_wr + CW'(1);
    end

    raddr = '0;
    for (int unsigned k = 0; k < NUM_UOPS; k++) begin
      raddr[k*AW+:AW] = head_q + AW'(k);
    end

    n_out = (count_q < CW'(NUM_UOPS)) ? count_q : CW'(NUM_UOPS);
    n_deq = (IN_stall || IN_invalidate) ? '0 : n_out;

    head_d  = head_q + n_deq[AW-1:0];
    tail_d  = tail_q + n_wr[AW-1:0];
    count_d = count_q + n_wr - n_deq;
  end

  // Invalid lanes drive all zeros; valid lanes carry the entry with bit 0 set
  always_comb begin
    OUT_valid = '0;
    OUT_uop   = '0;
    for (int unsigned k = 0; k < NUM_UOPS; k++) begin
      if (CW'(k) < n_out) begin
        OUT_valid[k]            = 1'b1;
        OUT_uop[k*UOP_W+:UOP_W] = rdata[k*UOP_W+:UOP_W] | UOP_W'(1);
      end
    end
`ifdef UOPQ_BYPASS_EN
    if (bypass) begin
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < NUM_UOPS; i++) begin
        if (enq[i]) begin
          OUT_valid[idx]            = 1'b1;
          OUT_uop[idx*UOP_W+:UOP_W] = IN_uop[i*UOP_W+:UOP_W] | UOP_W'(1);
          idx++;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || IN_invalidate) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  uop_queue_ram #(
    .NUM_UOPS (NUM_UOPS),
    .DEPTH    (DEPTH),
    .WIDTH    (UOP_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (IN_uop),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_uop_queue.sv
// Self-checking bench for uop_queue: table-driven occupancy vectors, directed
// corner sequences and random traffic against a FIFO reference model.
module tb_uop_queue;
  import uop_queue_pkg::*;

  localparam int N = 2;
  localparam int D = 8;
  localparam int W = 97;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   IN_uop;
  logic [N-1:0]     IN_valid;
  logic             OUT_ready;
  logic             IN_invalidate;
  logic             IN_stall;
  logic [N*W-1:0]   OUT_uop;
  logic [N-1:0]     OUT_valid;
  logic [$clog2(D):0] OUT_count;

  always #5 clk = ~clk;

  uop_queue #(
    .NUM_UOPS (N),
    .DEPTH    (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .IN_uop        (IN_uop),
    .IN_valid      (IN_valid),
    .OUT_ready     (OUT_ready),
    .IN_invalidate (IN_invalidate),
    .IN_stall      (IN_stall),
    .OUT_uop       (OUT_uop),
    .OUT_valid     (OUT_valid),
    .OUT_count     (OUT_count)
  );

  int errors = 0;
  int checks = 0;
  uop_t model_q[$];

  typedef struct {
    logic [N-1:0] v;
    logic         inv;
    logic         st;
    int           exp_cnt;
    logic         exp_rdy;
    logic [N-1:0] exp_v;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic uop_t rand_uop();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // One clock of stimulus; outputs are compared against the FIFO model before the edge
  task automatic cycle(input logic [N-1:0] v, input uop_t u0, input uop_t u1,
                       input logic inv, input logic st, input logic rs);
    uop_t         lanes[N];
    uop_t         exp_u[N];
    logic [N-1:0] exp_v;
    logic [N-1:0] en;
    logic         rdy;
    int           n_out;
    int           idx;
    bit           byp;
    @(negedge clk);
    lanes[0] = u0;
    lanes[1] = u1;
    rst = rs;
    IN_valid = v;
    IN_uop = {u1, u0};
    IN_invalidate = inv;
    IN_stall = st;
    #1;
    rdy = (D - model_q.size()) >= N;
    en = (rdy && !inv) ? v : '0;
    byp = 1'b0;
`ifdef UOPQ_BYPASS_EN
    byp = (model_q.size() == 0);
`endif
    exp_v = '0;
    for (int k = 0; k < N; k++) exp_u[k] = '0;
    n_out = 0;
    if (byp) begin
      idx = 0;
      for (int i = 0; i < N; i++) begin
        if (en[i]) begin
          exp_v[idx] = 1'b1;
          exp_u[idx] = lanes[i] | 97'd1;
          idx++;
        end
      end
    end else begin
      n_out = (model_q.size() < N) ? model_q.size() : N;
      for (int k = 0; k < n_out; k++) begin
        exp_v[k] = 1'b1;
        exp_u[k] = model_q[k] | 97'd1;
      end
    end
    chk("count", OUT_count, model_q.size());
    chk("ready", OUT_ready, rdy);
    chk("valid", OUT_valid, exp_v);
    for (int k = 0; k < N; k++) chk($sformatf("uop_lane%0d", k), OUT_uop[k*W+:W], exp_u[k]);
    if (rs || inv) begin
      model_q.delete();
    end else begin
      if (!st) repeat (n_out) void'(model_q.pop_front());
      if (!(byp && !st)) begin
        for (int i = 0; i < N; i++) if (en[i]) model_q.push_back(lanes[i]);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    uop_t a, b;
    rst = 1'b1;
    IN_valid = '0;
    IN_uop = '0;
    IN_invalidate = 1'b0;
    IN_stall = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_valid", OUT_valid, 2'b00);
    chk("reset_uop", OUT_uop, '0);
    chk("reset_count", OUT_count, 0);
    chk("reset_ready", OUT_ready, 1'b1);

    // Fill to full, blocked enqueue, partial refill, flush at count 5, drain
    tbl[0]  = '{2'b11, 1'b0, 1'b1, 2, 1'b1, 2'b11};
    tbl[1]  = '{2'b11, 1'b0, 1'b1, 4, 1'b1, 2'b11};
    tbl[2]  = '{2'b11, 1'b0, 1'b1, 6, 1'b1, 2'b11};
    tbl[3]  = '{2'b11, 1'b0, 1'b1, 8, 1'b0, 2'b11};
    tbl[4]  = '{2'b11, 1'b0, 1'b1, 8, 1'b0, 2'b11};
    tbl[5]  = '{2'b00, 1'b0, 1'b0, 6, 1'b1, 2'b11};
    tbl[6]  = '{2'b10, 1'b0, 1'b1, 7, 1'b0, 2'b11};
    tbl[7]  = '{2'b01, 1'b0, 1'b1, 7, 1'b0, 2'b11};
    tbl[8]  = '{2'b00, 1'b0, 1'b0, 5, 1'b1, 2'b11};
    tbl[9]  = '{2'b11, 1'b1, 1'b0, 0, 1'b1, 2'b00};
    tbl[10] = '{2'b10, 1'b0, 1'b1, 1, 1'b1, 2'b01};
    tbl[11] = '{2'b00, 1'b0, 1'b0, 0, 1'b1, 2'b00};
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      IN_valid = tbl[r].v;
      IN_uop = {rand_uop(), rand_uop()};
      IN_invalidate = tbl[r].inv;
      IN_stall = tbl[r].st;
      @(posedge clk);
      #1;
      IN_valid = '0;
      IN_invalidate = 1'b0;
      IN_stall = 1'b1;
      #1;
      chk($sformatf("tbl%0d_count", r), OUT_count, tbl[r].exp_cnt);
      chk($sformatf("tbl%0d_ready", r), OUT_ready, tbl[r].exp_rdy);
      chk($sformatf("tbl%0d_valid", r), OUT_valid, tbl[r].exp_v);
    end

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();

    // Sparse enqueue: lane 1 alone, then lane 0 alone, then a pair with stall released
    a = rand_uop();
    b = rand_uop();
    cycle(2'b10, rand_uop(), a, 1'b0, 1'b1, 1'b0);
    cycle(2'b01, b, rand_uop(), 1'b0, 1'b1, 1'b0);
    #2;
    chk("sparse_lane0", OUT_uop[0+:W], a | 97'd1);
    chk("sparse_lane1", OUT_uop[W+:W], b | 97'd1);
    cycle(2'b11, rand_uop(), rand_uop(), 1'b0, 1'b0, 1'b0);
    cycle(2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle(2'b00, '0, '0, 1'b0, 1'b0, 1'b0);

    // Empty queue, pair in with stall released
    cycle(2'b11, rand_uop(), rand_uop(), 1'b0, 1'b0, 1'b0);
    #2;
`ifdef UOPQ_BYPASS_EN
    chk("bypass_count", OUT_count, 0);
`else
    chk("nobypass_count", OUT_count, 2);
    chk("nobypass_valid", OUT_valid, 2'b11);
`endif
    cycle(2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle(2'b00, '0, '0, 1'b0, 1'b0, 1'b0);

    // Two in while stalled, then one in while draining: pointers wrap repeatedly
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) cycle(2'b11, rand_uop(), rand_uop(), 1'b0, 1'b1, 1'b0);
      else            cycle(2'b01, rand_uop(), rand_uop(), 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) cycle(2'b00, '0, '0, 1'b0, 1'b0, 1'b0);

    // Flush at count 5 with both lanes valid
    cycle(2'b11, rand_uop(), rand_uop(), 1'b0, 1'b1, 1'b0);
    cycle(2'b11, rand_uop(), rand_uop(), 1'b0, 1'b1, 1'b0);
    cycle(2'b10, rand_uop(), rand_uop(), 1'b0, 1'b1, 1'b0);
    cycle(2'b11, rand_uop(), rand_uop(), 1'b1, 1'b0, 1'b0);
    #2;
    chk("flush_count", OUT_count, 0);
    chk("flush_valid", OUT_valid, 2'b00);
    cycle(2'b00, '0, '0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      cycle(N'($urandom), rand_uop(), rand_uop(), ($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
